crc_slice4_engine: RTL and testbench
====================================

// Module: crc_slice4_engine
// PURPOSE
//  Frame-level CRC-32 engine, slicing-by-4: one 32-bit data word per clock.
//  Sits directly upstream of four crctab_* lookup ROM instances (TAB0..TAB3).
//  - Drives their addresses from (crc ^ data).
//  - XORs their read data into the running CRC.
//  - Emits the final CRC per frame on a valid/ready result port.
// PARAMETERS
//  INIT      32'hFFFFFFFF  CRC register value loaded at start of each frame
//  XOROUT    32'hFFFFFFFF  value XORed into the CRC to form res_crc
//  CNT_W     16            width of the per-frame word counter
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst         in   1      asynchronous reset, active-high
//  in_valid    in   1      input word valid
//  in_ready    out  1      engine accepts in_data this cycle
//  in_data     in   32     data word; byte0 = [7:0] is first on the wire
//  in_first    in   1      word is first of frame (qualified by in_valid)
//  in_last     in   1      word is last of frame (first&last = 1-word frame)
//  tab0_addr   out  32     TAB0 address {24'h0, x[31:24]}
//  tab1_addr   out  32     TAB1 address {24'h0, x[23:16]}
//  tab2_addr   out  32     TAB2 address {24'h0, x[15:8]}
//  tab3_addr   out  32     TAB3 address {24'h0, x[7:0]}
//  tab0..3_rdata in 32     combinational ROM read data, same cycle as address
//  res_valid   out  1      final CRC available
//  res_ready   in   1      consumer takes result
//  res_crc     out  32     crc_reg ^ XOROUT of completed frame
//  res_words   out  CNT_W  number of words in completed frame (saturating)
//  err_restart out  1      1-cycle pulse: in_first seen mid-frame
// BEHAVIOUR
//  - Reset values: state=IDLE, crc_reg=INIT, word_cnt=0, res_valid=0,
//    res_crc=0, res_words=0, err_restart=0.
//  - Accept: beat = in_valid & in_ready.
//    in_ready = (state!=DONE) | res_ready.
//  - Feedback value: x = base ^ in_data.
//    base = INIT if in_first else crc_reg.
//    crc_next = tab0_rdata ^ tab1_rdata ^ tab2_rdata ^ tab3_rdata.
//    Single-cycle loop, throughput 1 word/clk.
//  - tabN_addr are driven combinationally from x every cycle, including
//    non-beat cycles; upper 24 bits are always 0.
//  - FSM:
//    IDLE: beat & in_first & !in_last -> RUN; crc_reg<=crc_next; word_cnt<=1.
//          beat & in_first & in_last  -> DONE; result loaded.
//          beat & !in_first -> word dropped, state unchanged, no error.
//    RUN:  beat & !in_first -> crc_reg<=crc_next; word_cnt+=1 (saturates at
//          all-ones); if in_last -> DONE.
//          beat & in_first -> err_restart=1 next cycle; frame restarts from
//          INIT using this word (same rules as IDLE).
//    DONE: res_valid=1; res_crc/res_words held stable until res_ready.
//          res_ready & !beat -> IDLE, res_valid<=0.
//          res_ready & beat  -> result retired and the new word handled
//          as in IDLE in the same cycle; res_valid stays 1 only if that
//          word is first&last.
//  - Result load on the last beat: res_crc<=crc_next^XOROUT,
//    res_words<=word_cnt+1 (or 1 for a 1-word frame).
//    Latency: last beat -> res_valid 1 clk later.
//  - Async rst mid-frame: everything returns to reset values immediately;
//    the partial frame is lost and no result is emitted.
//  - Byte granularity: none. Frames are whole words only.
// TESTING (TAB0..3 = standard reflected CRC-32 slice tables, TAB0[1]=0x77073096)
//  1. Reset: assert rst mid-frame -> res_valid=0, in_ready=1, state IDLE.
//     Then 1-word frame 0x64636261 ("abcd") -> res_crc=0xED82CD11,
//     res_words=1 one clk after the beat.
//  2. 2-word frame 0x34333231, 0x38373635 ("12345678") at full rate
//     -> res_crc=0x9AE0DAAF, res_words=2.
//  3. Backpressure: hold res_ready=0 in DONE -> in_ready=0, result stable.
//     Assert res_ready with a new first&last word valid -> both handled in
//     one cycle; next result follows 1 clk later.
//  4. in_first mid-frame after 3 words -> err_restart pulses once; result
//     equals the CRC of the new frame only.
//  5. Words with in_first=0 while IDLE -> ignored, no res_valid,
//     no err_restart.
//  6. Bubbles: frame of test 2 with in_valid low between the two words
//     -> same 0x9AE0DAAF; tab addresses change but crc_reg does not.

Source files
------------

// File: rtl/crc_slice4_engine.sv
// CRC-32 slicing-by-4 frame engine: folds one 32-bit word per clock through four
// external slice-table ROMs and emits the finished CRC of each frame on a valid/ready port.
module crc_slice4_engine #(
    parameter logic [31:0] INIT   = 32'hFFFF_FFFF,
    parameter logic [31:0] XOROUT = 32'hFFFF_FFFF,
    parameter int          CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic [31:0]      tab0_addr,
    output logic [31:0]      tab1_addr,
    output logic [31:0]      tab2_addr,
    output logic [31:0]      tab3_addr,
    input  logic [31:0]      tab0_rdata,
    input  logic [31:0]      tab1_rdata,
    input  logic [31:0]      tab2_rdata,
    input  logic [31:0]      tab3_rdata,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_crc,
    output logic [CNT_W-1:0] res_words,
    output logic             err_restart
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_crc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_res_valid;
    logic [31:0]        r_res_crc;
    logic [CNT_W-1:0]   r_res_words;
    logic               r_err;

    state_t             w_state_nx;
    logic [31:0]        w_crc_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               w_res_valid_nx;
    logic [31:0]        w_res_crc_nx;
    logic [CNT_W-1:0]   w_res_words_nx;
    logic               w_err_nx;

    logic [31:0]        w_x;
    logic [31:0]        w_crc_next;
    logic               w_beat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A first word always restarts from INIT, so the table lookup never sees stale state.
    assign w_x        = (in_first ? INIT : r_crc) ^ in_data;
    assign tab0_addr  = {24'h0, w_x[31:24]};
    assign tab1_addr  = {24'h0, w_x[23:16]};
    assign tab2_addr  = {24'h0, w_x[15:8]};
    assign tab3_addr  = {24'h0, w_x[7:0]};
    assign w_crc_next = tab0_rdata ^ tab1_rdata ^ tab2_rdata ^ tab3_rdata;

    assign in_ready   = (r_state != S_DONE) | res_ready;
    assign w_beat     = in_valid & in_ready;

    always_comb begin
        w_state_nx     = r_state;
        w_crc_nx       = r_crc;
        w_cnt_nx       = r_cnt;
        w_res_valid_nx = r_res_valid;
        w_res_crc_nx   = r_res_crc;
        w_res_words_nx = r_res_words;
        w_err_nx       = 1'b0;

        if (r_state == S_DONE && res_ready) begin
            w_state_nx     = S_IDLE;
            w_res_valid_nx = 1'b0;
        end

        // After a retire, DONE behaves exactly like IDLE for the incoming word.
        if (w_beat) begin
            if (in_first) begin
                w_err_nx = (r_state == S_RUN);
                w_crc_nx = w_crc_next;
                w_cnt_nx = CNT_W'(1);
                if (in_last) begin
                    w_state_nx     = S_DONE;
                    w_res_valid_nx = 1'b1;
                    w_res_crc_nx   = w_crc_next ^ XOROUT;
                    w_res_words_nx = CNT_W'(1);
                end else begin
                    w_state_nx = S_RUN;
                end
            end else if (r_state == S_RUN) begin
                w_crc_nx = w_crc_next;
                w_cnt_nx = sat_inc(r_cnt);
                if (in_last) begin
                    w_state_nx     = S_DONE;
                    w_res_valid_nx = 1'b1;
                    w_res_crc_nx   = w_crc_next ^ XOROUT;
                    w_res_words_nx = sat_inc(r_cnt);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_crc       <= INIT;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_crc   <= '0;
            r_res_words <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_crc       <= w_crc_nx;
            r_cnt       <= w_cnt_nx;
            r_res_valid <= w_res_valid_nx;
            r_res_crc   <= w_res_crc_nx;
            r_res_words <= w_res_words_nx;
            r_err       <= w_err_nx;
        end
    end

    assign res_valid   = r_res_valid;
    assign res_crc     = r_res_crc;
    assign res_words   = r_res_words;
    assign err_restart = r_err;

endmodule

// File: tb/tb_crc_slice4_engine.sv
// Self-checking bench for crc_slice4_engine: slice-table ROMs are modelled here and every
// result is compared against a bytewise reflected CRC-32 reference.
module tb_crc_slice4_engine;

    localparam int CW = 4;   // narrow word counter so saturation is reachable quickly
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_first;
    logic          in_last;
    logic [31:0]   tab0_addr, tab1_addr, tab2_addr, tab3_addr;
    logic [31:0]   tab0_rdata, tab1_rdata, tab2_rdata, tab3_rdata;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_crc;
    logic [CW-1:0] res_words;
    logic          err_restart;

    logic [31:0] T0 [256];
    logic [31:0] T1 [256];
    logic [31:0] T2 [256];
    logic [31:0] T3 [256];

    int total = 0;
    int bad   = 0;

    crc_slice4_engine #(
        .INIT   (32'hFFFF_FFFF),
        .XOROUT (32'hFFFF_FFFF),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_first    (in_first),
        .in_last     (in_last),
        .tab0_addr   (tab0_addr),
        .tab1_addr   (tab1_addr),
        .tab2_addr   (tab2_addr),
        .tab3_addr   (tab3_addr),
        .tab0_rdata  (tab0_rdata),
        .tab1_rdata  (tab1_rdata),
        .tab2_rdata  (tab2_rdata),
        .tab3_rdata  (tab3_rdata),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_crc     (res_crc),
        .res_words   (res_words),
        .err_restart (err_restart)
    );

    always #5 clk = ~clk;

    assign tab0_rdata = T0[tab0_addr[7:0]];
    assign tab1_rdata = T1[tab1_addr[7:0]];
    assign tab2_rdata = T2[tab2_addr[7:0]];
    assign tab3_rdata = T3[tab3_addr[7:0]];

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Bytes go in wire order: [7:0] first.
    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 4; k++)
            r = crc_byte(r, w[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [CW-1:0] sat_words(input int n);
        return (n >= int'(CMAX)) ? CMAX : CW'(n);
    endfunction

    task automatic build_tables();
        for (int i = 0; i < 256; i++) T0[i] = crc_byte(32'h0, i[7:0]);
        for (int i = 0; i < 256; i++) T1[i] = (T0[i] >> 8) ^ T0[T0[i][7:0]];
        for (int i = 0; i < 256; i++) T2[i] = (T1[i] >> 8) ^ T0[T1[i][7:0]];
        for (int i = 0; i < 256; i++) T3[i] = (T2[i] >> 8) ^ T0[T2[i][7:0]];
    endtask

    // Presents one word and holds it until accepted; returns 1 ns after the accepting edge.
    task automatic beat(input logic [31:0] d, input logic f, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        in_last  = l;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in_data = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input int n, input int bub, output logic [31:0] ec,
                               output logic [CW-1:0] ew);
        logic [31:0] c;
        logic [31:0] w;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            c = crc_word(c, w);
            beat(w, i == 0, i == n - 1);
            if (bub > 0 && i < n - 1) idle($urandom_range(0, bub));
        end
        ec = c ^ 32'hFFFF_FFFF;
        ew = sat_words(n);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%0b req=0", res_valid); end
        total++; if (res_crc !== 32'h0) begin bad++; $display("FAIL rst_res_crc got=%h req=0", res_crc); end
        total++; if (res_words !== '0) begin bad++; $display("FAIL rst_res_words got=%0d req=0", res_words); end
        total++; if (err_restart !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b req=0", err_restart); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b req=1", in_ready); end
        rst = 1'b0;
        beat(32'h3433_3231, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        total++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midframe_rst valid=%0b ready=%0b req 0/1", res_valid, in_ready);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        in_data = 32'h0;
        in_first = 1'b0;
        #1;
        total++; if (tab0_addr !== 32'hFF || tab3_addr !== 32'hFF) begin
            bad++; $display("FAIL rst_crc_reg tab0=%h tab3=%h req=000000ff", tab0_addr, tab3_addr);
        end
        beat($urandom, 1'b0, 1'b1);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_state_idle res_valid=%0b req=0", res_valid); end
        beat(32'h6463_6261, 1'b1, 1'b1);
        e = crc_word(32'hFFFF_FFFF, 32'h6463_6261) ^ 32'hFFFF_FFFF;
        total++; if (res_valid !== 1'b1 || res_crc !== 32'hED82_CD11 || res_crc !== e) begin
            bad++; $display("FAIL abcd_crc valid=%0b crc=%h req=ed82cd11", res_valid, res_crc);
        end
        total++; if (res_words !== CW'(1)) begin bad++; $display("FAIL abcd_words got=%0d req=1", res_words); end
        idle(1);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL abcd_retire res_valid=%0b req=0", res_valid); end
    endtask

    task automatic test_two_word();
        beat(32'h3433_3231, 1'b1, 1'b0);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL two_mid_valid got=%0b req=0", res_valid); end
        beat(32'h3837_3635, 1'b0, 1'b1);
        total++; if (res_valid !== 1'b1 || res_crc !== 32'h9AE0_DAAF || res_words !== CW'(2)) begin
            bad++; $display("FAIL two_word valid=%0b crc=%h words=%0d req 1/9ae0daaf/2", res_valid, res_crc, res_words);
        end
        idle(1);
    endtask

    task automatic test_backpressure();
        logic [31:0] w1, w2, e1, e2;
        w1 = $urandom;
        w2 = $urandom;
        e1 = crc_word(32'hFFFF_FFFF, w1) ^ 32'hFFFF_FFFF;
        e2 = crc_word(32'hFFFF_FFFF, w2) ^ 32'hFFFF_FFFF;
        res_ready = 1'b0;
        beat(w1, 1'b1, 1'b1);
        in_valid = 1'b1; in_data = w2; in_first = 1'b1; in_last = 1'b1;
        repeat (3) begin
            #1;
            total++; if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_crc !== e1 || res_words !== CW'(1)) begin
                bad++; $display("FAIL bp_hold ready=%0b valid=%0b crc=%h req 0/1/%h", in_ready, res_valid, res_crc, e1);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release in_ready=%0b req=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        total++; if (res_valid !== 1'b1 || res_crc !== e2 || res_words !== CW'(1)) begin
            bad++; $display("FAIL bp_next valid=%0b crc=%h req 1/%h", res_valid, res_crc, e2);
        end
        idle(1);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_retire res_valid=%0b req=0", res_valid); end
    endtask

    task automatic test_restart();
        logic [31:0] a, b, e;
        int pulses;
        pulses = 0;
        beat($urandom, 1'b1, 1'b0); pulses += int'(err_restart);
        beat($urandom, 1'b0, 1'b0); pulses += int'(err_restart);
        beat($urandom, 1'b0, 1'b0); pulses += int'(err_restart);
        a = $urandom;
        b = $urandom;
        e = crc_word(crc_word(32'hFFFF_FFFF, a), b) ^ 32'hFFFF_FFFF;
        beat(a, 1'b1, 1'b0);
        total++; if (err_restart !== 1'b1) begin bad++; $display("FAIL restart_pulse got=%0b req=1", err_restart); end
        pulses += int'(err_restart);
        beat(b, 1'b0, 1'b1);
        pulses += int'(err_restart);
        total++; if (pulses != 1) begin bad++; $display("FAIL restart_pulse_count got=%0d req=1", pulses); end
        total++; if (res_valid !== 1'b1 || res_crc !== e || res_words !== CW'(2)) begin
            bad++; $display("FAIL restart_crc valid=%0b crc=%h words=%0d req 1/%h/2", res_valid, res_crc, res_words, e);
        end
        idle(1);
    endtask

    task automatic test_idle_drop();
        logic [31:0] e;
        logic [CW-1:0] n;
        for (int i = 0; i < 6; i++) begin
            beat($urandom, 1'b0, 1'($urandom_range(0, 1)));
            total++; if (res_valid !== 1'b0 || err_restart !== 1'b0) begin
                bad++; $display("FAIL idle_drop[%0d] valid=%0b err=%0b req 0/0", i, res_valid, err_restart);
            end
        end
        drive_frame(3, 0, e, n);
        total++; if (res_valid !== 1'b1 || res_crc !== e || res_words !== n) begin
            bad++; $display("FAIL idle_then_frame crc=%h words=%0d req %h/%0d", res_crc, res_words, e, n);
        end
        idle(1);
    endtask

    task automatic test_bubbles();
        logic [31:0] c1, x;
        c1 = crc_word(32'hFFFF_FFFF, 32'h3433_3231);
        beat(32'h3433_3231, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            in_data  = $urandom;
            in_first = (i == 2);
            x = (in_first ? 32'hFFFF_FFFF : c1) ^ in_data;
            #1;
            total++; if (tab0_addr !== {24'h0, x[31:24]} || tab1_addr !== {24'h0, x[23:16]} ||
                         tab2_addr !== {24'h0, x[15:8]} || tab3_addr !== {24'h0, x[7:0]}) begin
                bad++; $display("FAIL bubble_addr[%0d] got=%h,%h,%h,%h req x=%h", i,
                                tab0_addr, tab1_addr, tab2_addr, tab3_addr, x);
            end
            @(posedge clk);
            #1;
        end
        in_first = 1'b0;
        beat(32'h3837_3635, 1'b0, 1'b1);
        total++; if (res_valid !== 1'b1 || res_crc !== 32'h9AE0_DAAF || res_words !== CW'(2)) begin
            bad++; $display("FAIL bubble_crc crc=%h words=%0d req 9ae0daaf/2", res_crc, res_words);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic [CW-1:0] n;
        for (int f = 0; f < 8; f++) begin
            drive_frame($urandom_range(1, 5), (f % 2) * 2, e, n);
            total++; if (res_valid !== 1'b1 || res_crc !== e || res_words !== n) begin
                bad++; $display("FAIL b2b[%0d] valid=%0b crc=%h words=%0d req 1/%h/%0d", f, res_valid, res_crc, res_words, e, n);
            end
        end
        drive_frame(20, 0, e, n);
        total++; if (res_crc !== e || res_words !== CMAX) begin
            bad++; $display("FAIL saturate crc=%h words=%0d req %h/%0d", res_crc, res_words, e, CMAX);
        end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        build_tables();
        @(posedge clk);
        #1;
        test_reset();
        test_two_word();
        test_backpressure();
        test_restart();
        test_idle_drop();
        test_bubbles();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
